// File: rtl/dispatch_2_af.sv
// One-to-two stream dispatcher with a FIFO per output,
// almost-full feedback to the source and per-output word counters.
module dispatch_2_af #(
  parameter int DWIDTH     = 8,
  parameter int DEPTH      = 16,
  parameter int FULL_LEVEL = 12,
  parameter int RR_MODE    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_dest,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              in_almost_full,
  output logic [DWIDTH-1:0] out_data_0,
  output logic [DWIDTH-1:0] out_data_1,
  output logic              out_valid_0,
  output logic              out_valid_1,
  input  logic              out_ready_0,
  input  logic              out_ready_1,
  output logic [31:0]       cnt_0,
  output logic [31:0]       cnt_1
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [DWIDTH-1:0] mem_q [2][DEPTH];
  logic [AW-1:0]     wp_q  [2];
  logic [AW-1:0]     rp_q  [2];
  logic [OW-1:0]     occ_q [2];
  logic [OW-1:0]     occ_d [2];
  logic [31:0]       cnt_q [2];
  logic              rr_q;
  logic              af_q;
  logic              af_d;

  logic       tgt;
  logic       acc;
  logic [1:0] full;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] ordy;

  assign ordy = {out_ready_1, out_ready_0};
  assign tgt  = (RR_MODE != 0) ? rr_q : in_dest;
  assign full = {occ_q[1] == OW'(DEPTH),
                 occ_q[0] == OW'(DEPTH)};

  // No bypass: a full FIFO refuses even when it pops this cycle
  assign in_ready = !full[tgt];
  assign acc      = in_valid & in_ready;

  always_comb begin
    push = '0;
    pop  = '0;
    for (int k = 0; k < 2; k++) begin
      push[k]  = acc & (tgt == 1'(k));
      pop[k]   = (occ_q[k] != '0) & ordy[k];
      occ_d[k] = occ_q[k] + OW'(push[k]) - OW'(pop[k]);
    end
    af_d = (occ_d[0] >= OW'(FULL_LEVEL)) |
           (occ_d[1] >= OW'(FULL_LEVEL));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        occ_q[k] <= '0;
        wp_q[k]  <= '0;
        rp_q[k]  <= '0;
        cnt_q[k] <= '0;
      end
      rr_q <= 1'b0;
      af_q <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        occ_q[k] <= occ_d[k];
        if (push[k]) begin
          wp_q[k]  <= wp_q[k] + 1'b1;
          cnt_q[k] <= cnt_q[k] + 32'd1;
        end
        if (pop[k]) rp_q[k] <= rp_q[k] + 1'b1;
      end
      if (acc) rr_q <= ~rr_q;
      af_q <= af_d;
    end
  end

  // Storage needs no reset; occupancy gates every read
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (push[k]) mem_q[k][wp_q[k]] <= in_data;
    end
  end

  assign out_data_0     = mem_q[0][rp_q[0]];
  assign out_data_1     = mem_q[1][rp_q[1]];
  assign out_valid_0    = occ_q[0] != '0;
  assign out_valid_1    = occ_q[1] != '0;
  assign in_almost_full = af_q;
  assign cnt_0          = cnt_q[0];
  assign cnt_1          = cnt_q[1];

endmodule

// File: doc/dispatch_2_af.md
# dispatch_2_af

One-to-two dispatcher that fans a single ready/valid stream out to two downstream consumers, with a buffering FIFO per output and an almost-full indication back to the source. It is the distribution counterpart of the two-input arbiter service: it sits where one producer feeds two parallel engines and must absorb short per-engine stalls. Routing is either explicit (per-word destination bit) or round-robin, fixed by parameter. Per-output accepted-word counters are provided for statistics.

## Interface
- DWIDTH, 8, data word width.
- DEPTH, 16, entries per output FIFO; power of two, >= 4.
- FULL_LEVEL, 12, occupancy at or above which an output counts as almost full; 1 <= FULL_LEVEL <= DEPTH.
- RR_MODE, 0, 0 = route by in_dest; 1 = round-robin, in_dest ignored.

- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  reset, asynchronous and active-high.
- in_data  in  DWIDTH  input word.
- in_dest  in  1  destination output (0/1), qualified by in_valid; used only when RR_MODE=0.
- in_valid  in  1  input word valid.
- in_ready  out  1  dispatcher accepts the word this cycle.
- in_almost_full  out  1  either output FIFO occupancy >= FULL_LEVEL.
- out_data_0 / out_data_1  out  DWIDTH  head word of each FIFO.
- out_valid_0 / out_valid_1  out  1  FIFO non-empty.
- out_ready_0 / out_ready_1  in  1  consumer takes head word.
- cnt_0 / cnt_1  out  32  words accepted toward each output, wraps modulo 2^32.

## Operation
- Target select: RR_MODE=0 -> tgt = in_dest; RR_MODE=1 -> tgt = rr_ptr.
- in_ready = !full[tgt] (combinational from in_dest and FIFO state; no dependence on in_valid or out_ready). No bypass: a full FIFO refuses input even if it pops the same cycle.
- Accept = in_valid & in_ready: in_data written to FIFO[tgt], occ[tgt]++, cnt_tgt++.
- rr_ptr toggles only on accept; a refused word keeps rr_ptr (source must hold data/valid until accepted). Round-robin is strict alternation: no skipping to the non-full output.
- Pop on out_valid_k & out_ready_k: read pointer k advances, occ[k]--.
- Simultaneous push and pop on same FIFO: occ unchanged, both pointers advance; legal at any occupancy including 1 (non-empty) and DEPTH-1.
- Occupancy counters clog2(DEPTH)+1 bits, range 0..DEPTH; full = occ==DEPTH, empty = occ==0. Pointers clog2(DEPTH) bits, wrap naturally DEPTH-1 -> 0.
- in_almost_full = (occ0 >= FULL_LEVEL) | (occ1 >= FULL_LEVEL), registered from post-update occupancy.
- Word order preserved per output; no ordering across outputs.
- out_data_k unspecified while out_valid_k = 0; checkers compare only when valid.

## Timing
- Reset (async assert, sync release on next edge): occ = 0, pointers = 0, rr_ptr = 0, cnt_0/cnt_1 = 0, out_valid_0/1 = 0, in_almost_full = 0, in_ready = 1.
- Reset mid-operation: all buffered words discarded; outputs return to reset values immediately (asynchronous).
- Latency: word accepted at edge N -> out_valid_k = 1 and out_data_k = word after edge N (visible cycle N+1). Minimum input-to-output latency 1 cycle.
- Throughput: one accept per cycle and one pop per output per cycle sustained.
- in_almost_full reflects occupancy after edge N, one cycle after the crossing push/pop.
- cnt_k updates at the accepting edge.

## Test plan
- Explicit route: RR_MODE=0, push 0xA1(dest0), 0xB2(dest1), 0xC3(dest0), both readys high -> out0 gives 0xA1,0xC3; out1 gives 0xB2; cnt_0=2, cnt_1=1; each word valid 1 cycle after accept.
- Round-robin: RR_MODE=1, push 0x01..0x06 back-to-back with readys high -> out0 0x01,0x03,0x05; out1 0x02,0x04,0x06.
- Full/backpressure: out_ready_0=0, push 16 words dest0 -> in_almost_full rises the cycle after 12th accept, in_ready low with dest0 after 16th; dest1 word still accepted same cycle; release out_ready_0 -> 16 words drain in order.
- Strict RR stall: RR_MODE=1, out1 FIFO full, rr_ptr=1 -> in_ready=0, rr_ptr holds; out0 not used until out1 pops one word.
- Push+pop at occupancy 16 and 1: at full, push refused while pop proceeds (occ 15); at occ 1 with simultaneous push/pop, occ stays 1, out_valid stays 1, pointer wrap across entry 15->0 verified with 40-word stream.
- Reset mid-stream: assert rst with 5 words buffered -> out_valid_0/1 drop immediately, cnts 0, in_ready=1; post-release push 0x55 -> appears cycle after accept.
